czono_op_sequencer: RTL
=======================

# czono_op_sequencer

Command sequencer for the constrained-zonotope operator units (`plus`, `linear_image`, `intersection`).
- Accepts one operation command at a time over a valid/ready handshake.
- Checks operand dimensions against the compile-time capacities of the `CZonotope` and `linear_transform` containers.
- Pulses the start of the selected unit, waits for its done, and returns a status and cycle count over a second valid/ready handshake.
- Sits between the host/command layer and the operator datapaths; operand storage itself stays outside this block.

## Interface
- `NMAX`, 10, max state dimension n
- `NGMAX`, 5, max generators per input zonotope
- `NCMAX`, 3, max constraints per input zonotope
- `NRMAX`, 10, max rows of R
- `DIM_W`, 8, width of every dimension field
- `CNT_W`, 16, width of cycle counter
- `TIMEOUT`, 1024, watchdog limit in WAIT cycles (used only with the watchdog, see Configuration)

- `clk_i` in 1 — clock
- `rstn_i` in 1 — reset, asynchronous, active-low
- `cmd_valid_i` in 1 — command valid
- `cmd_ready_o` out 1 — command ready
- `cmd_op_i` in 2 — opcode: 0 PLUS, 1 IMAGE, 2 INTERSECT, 3 reserved
- `z_n_i`, `z_ng_i`, `z_nc_i` in DIM_W each — Z dimensions
- `w_n_i`, `w_ng_i`, `w_nc_i` in DIM_W each — W/Y dimensions
- `r_n_i`, `r_nr_i` in DIM_W each — R columns and rows
- `start_plus_o`, `start_image_o`, `start_inter_o` out 1 each — one-cycle start pulses
- `done_plus_i`, `done_image_i`, `done_inter_i` in 1 each — unit completion
- `busy_o` out 1 — high in every state except IDLE
- `rsp_valid_o` out 1 — response valid
- `rsp_ready_i` in 1 — response ready
- `rsp_op_o` out 2 — opcode of the completed command
- `rsp_status_o` out 2 — 0 OK, 1 ERR_DIM, 2 TIMEOUT, 3 ERR_OP
- `rsp_cycles_o` out CNT_W — WAIT cycle count

## Operation
**States:** IDLE, CHECK, START, WAIT, RESP.

**IDLE**
- `cmd_ready_o`=1.
- On `cmd_valid_i & cmd_ready_o`: register the opcode and all dimension fields, then go to CHECK.

**CHECK** (one cycle): evaluate legality from the registered fields.
- All sums are computed at DIM_W+2 bits, so no overflow is possible.
- Opcode 3 → status ERR_OP, go to RESP. ERR_OP takes precedence over ERR_DIM.
- PLUS is legal when all hold:
  - z_n==w_n
  - 1≤z_n≤NMAX
  - z_ng+w_ng≤2·NGMAX
  - z_nc+w_nc≤2·NCMAX
- IMAGE is legal when all hold:
  - r_n==z_n
  - z_n≤NMAX
  - 1≤r_nr≤NRMAX
  - z_ng≤NGMAX
  - z_nc≤NCMAX
- INTERSECT is legal when all hold:
  - r_n==z_n
  - r_nr==w_n
  - z_n≤NMAX
  - r_nr≤NRMAX
  - z_ng+w_ng≤2·NGMAX
  - z_nc+w_nc+r_nr≤2·NCMAX+NRMAX
- Illegal → status ERR_DIM, `rsp_cycles_o`=0, go to RESP.
- Legal → go to START.

**START**
- Assert only the selected `start_*_o` for exactly one cycle.
- Clear the counter to 0, go to WAIT.

**WAIT**
- Counter increments every cycle and saturates at all-ones.
- Only the selected unit's done is sampled; done inputs of the other units are ignored.
- When the selected done is high, latch cycles = counter+1 (saturating) and status OK, go to RESP.

**RESP**
- `rsp_valid_o`=1; `rsp_op_o`, `rsp_status_o` and `rsp_cycles_o` are held stable until `rsp_ready_i`.
- On handshake, return to IDLE.

**Other rules**
- Done inputs are sampled as levels: a pulse or a level both complete the operation.
- Reset mid-operation:
  - All state is abandoned; FSM goes to IDLE.
  - No start pulse is emitted after reset.
  - The operator units share `rstn_i`, so the in-flight operation is also abandoned.

## Timing
**Reset values**
- `cmd_ready_o`=1 (IDLE).
- All of the following are 0: start pulses, `busy_o`, `rsp_valid_o`, `rsp_op_o`, `rsp_status_o`, `rsp_cycles_o`.

**Latency**
- Command accept (cycle 0) → CHECK (1) → START pulse (2) → WAIT from cycle 3.
- Done sampled in WAIT cycle k (k≥1) → `rsp_valid_o` high the next cycle with `rsp_cycles_o`=k.
- Error path: accept (0) → `rsp_valid_o` at cycle 2.

**Throughput**
- `cmd_ready_o` stays low from the cycle after accept until the cycle after the response handshake.
- The next command can therefore be accepted one cycle after `rsp_valid_o & rsp_ready_i`.

**Other timing rules**
- Done asserted during CHECK or START is ignored; the units take at least 1 cycle after the start pulse.
- `cmd_valid_i` outside IDLE has no effect.

## Configuration
**`CZ_OP_TIMEOUT_EN`**
- Defined: in WAIT, if the counter reaches TIMEOUT without the selected done, go to RESP with status TIMEOUT and `rsp_cycles_o`=TIMEOUT.
  - If the selected done arrives in that same cycle, OK wins.
- Undefined: WAIT persists indefinitely; the counter saturates; status TIMEOUT is never produced.

## Test plan
- PLUS, Z(n2,ng3,nc1) + W(n2,ng2,nc1), done_plus after 4 WAIT cycles → one start_plus pulse at cycle 2, rsp status 0, op 0, cycles 4.
- INTERSECT with r_n=2, r_nr=2, Z(2,3,1), W(2,2,1) → start_inter only; other done inputs toggling are ignored; status 0.
- IMAGE with r_n=3, z_n=2 → no start pulse, status 1, cycles 0, response at cycle 2. Opcode 3 → status 3.
- Response backpressure: hold rsp_ready_i low 5 cycles → rsp fields stable and cmd_ready_o=0; the next command is accepted the cycle after the handshake.
- With CZ_OP_TIMEOUT_EN and TIMEOUT=8, done never asserted → status 2, cycles 8. Without the macro → still busy after 100 cycles.
- Assert rstn_i low during WAIT → all outputs at reset values immediately; after release a new PLUS completes normally.

Source files
------------

// File: rtl/czono_op_sequencer.sv
// rtl/czono_op_sequencer.sv - command sequencer for the constrained-zonotope operator units
// Optional watchdog: define CZ_OP_TIMEOUT_EN to end WAIT with status TIMEOUT after TIMEOUT cycles.
module czono_op_sequencer #(
    parameter int NMAX    = 10,
    parameter int NGMAX   = 5,
    parameter int NCMAX   = 3,
    parameter int NRMAX   = 10,
    parameter int DIM_W   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [DIM_W-1:0] z_n_i,
    input  logic [DIM_W-1:0] z_ng_i,
    input  logic [DIM_W-1:0] z_nc_i,
    input  logic [DIM_W-1:0] w_n_i,
    input  logic [DIM_W-1:0] w_ng_i,
    input  logic [DIM_W-1:0] w_nc_i,
    input  logic [DIM_W-1:0] r_n_i,
    input  logic [DIM_W-1:0] r_nr_i,
    output logic             start_plus_o,
    output logic             start_image_o,
    output logic             start_inter_o,
    input  logic             done_plus_i,
    input  logic             done_image_i,
    input  logic             done_inter_i,
    output logic             busy_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_op_o,
    output logic [1:0]       rsp_status_o,
    output logic [CNT_W-1:0] rsp_cycles_o
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_START, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] OP_PLUS   = 2'd0;
    localparam logic [1:0] OP_IMAGE  = 2'd1;
    localparam logic [1:0] OP_INTER  = 2'd2;
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_DIM    = 2'd1;
    localparam logic [1:0] ST_TOUT   = 2'd2;
    localparam logic [1:0] ST_OP     = 2'd3;
    localparam int         SW        = DIM_W + 2;

`ifdef CZ_OP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [DIM_W-1:0]   z_n_q, z_n_d, z_ng_q, z_ng_d, z_nc_q, z_nc_d;
    logic [DIM_W-1:0]   w_n_q, w_n_d, w_ng_q, w_ng_d, w_nc_q, w_nc_d;
    logic [DIM_W-1:0]   r_n_q, r_n_d, r_nr_q, r_nr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         status_q, status_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;

    // Dimensions widened by two bits so three-term sums cannot wrap.
    logic [SW-1:0] zn, zng, znc, wn, wng, wnc, rn, rnr;
    logic          plus_ok, image_ok, inter_ok, dims_ok, done_sel;

    assign zn  = SW'(z_n_q);
    assign zng = SW'(z_ng_q);
    assign znc = SW'(z_nc_q);
    assign wn  = SW'(w_n_q);
    assign wng = SW'(w_ng_q);
    assign wnc = SW'(w_nc_q);
    assign rn  = SW'(r_n_q);
    assign rnr = SW'(r_nr_q);

    assign plus_ok  = (zn == wn) && (zn >= SW'(1)) && (zn <= SW'(NMAX))
                   && (zng + wng <= SW'(2*NGMAX)) && (znc + wnc <= SW'(2*NCMAX));
    assign image_ok = (rn == zn) && (zn <= SW'(NMAX)) && (rnr >= SW'(1)) && (rnr <= SW'(NRMAX))
                   && (zng <= SW'(NGMAX)) && (znc <= SW'(NCMAX));
    assign inter_ok = (rn == zn) && (rnr == wn) && (zn <= SW'(NMAX)) && (rnr <= SW'(NRMAX))
                   && (zng + wng <= SW'(2*NGMAX))
                   && (znc + wnc + rnr <= SW'(2*NCMAX + NRMAX));

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        dims_ok  = 1'b0;
        done_sel = 1'b0;
        case (op_q)
            OP_PLUS:  begin dims_ok = plus_ok;  done_sel = done_plus_i;  end
            OP_IMAGE: begin dims_ok = image_ok; done_sel = done_image_i; end
            OP_INTER: begin dims_ok = inter_ok; done_sel = done_inter_i; end
            default:  begin dims_ok = 1'b0;     done_sel = 1'b0;         end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        z_n_d    = z_n_q;
        z_ng_d   = z_ng_q;
        z_nc_d   = z_nc_q;
        w_n_d    = w_n_q;
        w_ng_d   = w_ng_q;
        w_nc_d   = w_nc_q;
        r_n_d    = r_n_q;
        r_nr_d   = r_nr_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    z_n_d   = z_n_i;
                    z_ng_d  = z_ng_i;
                    z_nc_d  = z_nc_i;
                    w_n_d   = w_n_i;
                    w_ng_d  = w_ng_i;
                    w_nc_d  = w_nc_i;
                    r_n_d   = r_n_i;
                    r_nr_d  = r_nr_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (op_q == ST_OP) begin
                    status_d = ST_OP;
                    cycles_d = '0;
                    state_d  = S_RESP;
                end else if (!dims_ok) begin
                    status_d = ST_DIM;
                    cycles_d = '0;
                    state_d  = S_RESP;
                end else begin
                    state_d  = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (done_sel) begin
                    status_d = ST_OK;
                    cycles_d = cnt_inc;
                    state_d  = S_RESP;
                end else if (TO_EN && (cnt_inc == CNT_W'(TIMEOUT))) begin
                    status_d = ST_TOUT;
                    cycles_d = CNT_W'(TIMEOUT);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            z_n_q    <= '0;
            z_ng_q   <= '0;
            z_nc_q   <= '0;
            w_n_q    <= '0;
            w_ng_q   <= '0;
            w_nc_q   <= '0;
            r_n_q    <= '0;
            r_nr_q   <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            z_n_q    <= z_n_d;
            z_ng_q   <= z_ng_d;
            z_nc_q   <= z_nc_d;
            w_n_q    <= w_n_d;
            w_ng_q   <= w_ng_d;
            w_nc_q   <= w_nc_d;
            r_n_q    <= r_n_d;
            r_nr_q   <= r_nr_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            cycles_q <= cycles_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rsp_valid_o   = (state_q == S_RESP);
    assign start_plus_o  = (state_q == S_START) && (op_q == OP_PLUS);
    assign start_image_o = (state_q == S_START) && (op_q == OP_IMAGE);
    assign start_inter_o = (state_q == S_START) && (op_q == OP_INTER);
    assign rsp_op_o      = op_q;
    assign rsp_status_o  = status_q;
    assign rsp_cycles_o  = cycles_q;

endmodule
